// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the unified-memory arbiter of the multicycle RISC-V.
// Holds the arbiter state encoding, owner codes and a one-hot owner helper.
package rv_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;

  // One-hot done vector for a given owner ([0]=core, [1]=loader).
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// Combinational 2-way requester picker.
// Macro MEM_ARB_RR_EN: when defined, contention (2'b11) goes to the requester
// that did not win last time; when undefined, the core always wins.
module rv_rr_pick
  import rv_mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_owner,
  output logic       o_valid
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority ignores the history bit.
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  // Pick an owner from the live request vector.
  always_comb begin
    o_valid = |i_req;
    o_owner = OWN_CORE;
    if (i_req == 2'b10) begin
      o_owner = OWN_LDR;
    end else if (i_req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      o_owner = ~i_last;
`else
      o_owner = OWN_CORE;
`endif
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Two-requester arbiter/sequencer sharing one fixed-latency memory port
// between the core (requester 0) and the loader/DMA (requester 1).
// Macro MEM_ARB_RR_EN selects round-robin arbitration (see rv_rr_pick).
// Handshake: a requester raises req and holds it (with stable intent) until
// it samples its done bit high; only the we/addr/wdata present in the IDLE
// cycle where the grant happens are used, later changes are ignored.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic [1:0]    o_done,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output arb_state_t    o_state
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  arb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic          r_last;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_owner;
  logic          w_valid;
  logic [AW-1:0] w_sel_addr;

  rv_rr_pick u_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_owner (w_owner),
    .o_valid (w_valid)
  );

  assign w_sel_addr = w_owner ? i_addr1 : i_addr0;

  // Arbiter FSM: latch the winner in IDLE, count LAT busy cycles, pulse done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_owner <= OWN_CORE;
      r_last  <= OWN_LDR;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_owner <= w_owner;
            r_we    <= w_owner ? i_we[1] : i_we[0];
            r_addr  <= {w_sel_addr[AW-1:2], 2'b00};
            r_wdata <= w_owner ? i_wdata1 : i_wdata0;
            r_cnt   <= CW'(LAT - 1);
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (r_cnt == '0) begin
            r_rdata <= i_mem_rdata;
            r_state <= ARB_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ARB_DONE: begin
          r_last  <= r_owner;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_mem_req   = (r_state == ARB_BUSY);
  assign o_mem_we    = (r_state == ARB_BUSY) & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = (r_state != ARB_IDLE);
  assign o_done      = (r_state == ARB_DONE) ? owner_onehot(r_owner) : 2'b00;
  assign o_rdata     = r_rdata;
  assign o_state     = r_state;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed cases plus randomized traffic checked
// against a transaction-level reference (pending requests, policy rule,
// word-addressed memory model). Build with MEM_ARB_RR_EN for round-robin.
module tb_rv_mem_arb;
  import rv_mem_arb_pkg::*;

  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT (LAT=2) ----------------
  logic [1:0]    req, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, mem_rdata;
  logic [1:0]    done;
  logic [DW-1:0] rdata, mem_wdata;
  logic          busy, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  arb_state_t    state;

  rv_mem_arb #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_done(done), .o_rdata(rdata), .o_busy(busy), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_state(state)
  );

  // ---------------- latency-variant DUTs (LAT=1, LAT=5) ----------------
  logic [1:0]    x_we = 2'b00;
  logic [AW-1:0] x_addr0 = 32'h44, x_addr1 = '0;
  logic [DW-1:0] x_wdata = '0, x_mem_rdata = 32'hCAFE0000;
  logic [1:0]    l1_req, l5_req, l1_done, l5_done;
  logic [DW-1:0] l1_rdata, l5_rdata, l1_mem_wdata, l5_mem_wdata;
  logic          l1_busy, l5_busy, l1_mem_req, l5_mem_req, l1_mem_we, l5_mem_we;
  logic [AW-1:0] l1_mem_addr, l5_mem_addr;
  arb_state_t    l1_state, l5_state;

  rv_mem_arb #(.LAT(1), .AW(AW), .DW(DW)) dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_req(l1_req), .i_we(x_we),
    .i_addr0(x_addr0), .i_addr1(x_addr1), .i_wdata0(x_wdata), .i_wdata1(x_wdata),
    .o_done(l1_done), .o_rdata(l1_rdata), .o_busy(l1_busy), .o_mem_req(l1_mem_req),
    .o_mem_we(l1_mem_we), .o_mem_addr(l1_mem_addr), .o_mem_wdata(l1_mem_wdata),
    .i_mem_rdata(x_mem_rdata), .o_state(l1_state)
  );

  rv_mem_arb #(.LAT(5), .AW(AW), .DW(DW)) dut_l5 (
    .i_clk(clk), .i_rst(rst), .i_req(l5_req), .i_we(x_we),
    .i_addr0(x_addr0), .i_addr1(x_addr1), .i_wdata0(x_wdata), .i_wdata1(x_wdata),
    .o_done(l5_done), .o_rdata(l5_rdata), .o_busy(l5_busy), .o_mem_req(l5_mem_req),
    .o_mem_we(l5_mem_we), .o_mem_addr(l5_mem_addr), .o_mem_wdata(l5_mem_wdata),
    .i_mem_rdata(x_mem_rdata), .o_state(l5_state)
  );

  // ---------------- reference model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [1:0]    pend;
  logic          p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  logic          model_last;
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];

  // ---------------- scoreboard compare ----------------
  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return '0;
  endfunction

  // Owner chosen by the arbitration rules from the set of pending requesters.
  function automatic logic model_pick();
    if (pend == 2'b10) return 1'b1;
    if (pend == 2'b01) return 1'b0;
`ifdef MEM_ARB_RR_EN
    return ~model_last;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    req    = pend;
    we     = {p_we[1], p_we[0]};
    addr0  = p_addr[0];
    addr1  = p_addr[1];
    wdata0 = p_wdata[0];
    wdata1 = p_wdata[1];
  endtask

  task automatic new_txn(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i]    = 1'b1;
    p_we[i]    = w;
    p_addr[i]  = a;
    p_wdata[i] = d;
  endtask

  task automatic rand_txn(input int i);
    new_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom());
  endtask

  // Runs one access from the IDLE cycle where requests are already driven.
  task automatic step_access(input bit scramble, input bit drop, output logic owner_seen);
    logic          own;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er;
    own = model_pick();
    ew  = p_we[own];
    ea  = p_addr[own] & ~32'h3;
    ed  = p_wdata[own];
    er  = mem_rd(ea);
    if (!ew) exp_q.push_back(er);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      check_eq("busy_mem_req", 32'(mem_req), 32'd1);
      check_eq("busy_mem_addr", mem_addr, ea);
      check_eq("busy_mem_we", 32'(mem_we), 32'(ew));
      if (ew) check_eq("busy_mem_wdata", mem_wdata, ed);
      check_eq("busy_done", 32'(done), 32'd0);
      check_eq("busy_busy", 32'(busy), 32'd1);
      mem_rdata = (c == LAT) ? er : $urandom();
      if (c == 1) begin
        if (scramble) begin
          p_addr[own]  = 32'h300;
          p_wdata[own] = $urandom();
          p_we[own]    = ~p_we[own];
        end
        if (!pend[!own] && $urandom_range(0, 3) == 0) rand_txn(int'(!own));
        drive_reqs();
        if (drop) req[own] = 1'b0;
      end
    end
    @(posedge clk); #1;
    check_eq("done_vec", 32'(done), own ? 32'd2 : 32'd1);
    owner_seen = done[1];
    if (!ew) check_eq("done_rdata", rdata, exp_q.pop_front());
    check_eq("done_busy", 32'(busy), 32'd1);
    check_eq("done_mem_req", 32'(mem_req), 32'd0);
    if (ew) mem_model[ea] = ed;
    model_last = own;
    pend[own]  = 1'b0;
    drive_reqs();
    @(posedge clk); #1;
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic own_s;
  logic exp_seq [3];
  int   done_cyc, mreq_cnt, done_cnt;
  logic [DW-1:0] rd_seen;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1;
    pend = 2'b00;
    model_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    drive_reqs();
    mem_rdata = '0;
    l1_req = 2'b00;
    l5_req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state), 32'(ARB_IDLE));
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Core read of 0x104 returning 0xDEADBEEF.
    mem_model[32'h104] = 32'hDEADBEEF;
    new_txn(0, 1'b0, 32'h104, 32'h0);
    drive_reqs();
    step_access(1'b0, 1'b0, own_s);
    check_eq("t1_owner", 32'(own_s), 32'd0);

    // Loader write to 0x203 (word 0x200).
    new_txn(1, 1'b1, 32'h203, 32'h55);
    drive_reqs();
    step_access(1'b0, 1'b0, own_s);
    check_eq("t2_owner", 32'(own_s), 32'd1);

    // Both requesters held for three back-to-back accesses.
    for (int k = 0; k < 3; k++) begin
      if (!pend[0]) rand_txn(0);
      if (!pend[1]) rand_txn(1);
      drive_reqs();
      step_access(1'b0, 1'b0, own_s);
      check_eq("t3_owner_seq", 32'(own_s), 32'(exp_seq[k]));
    end
    while (pend != 2'b00) step_access(1'b0, 1'b0, own_s);

    // Inputs change and req drops during BUSY.
    new_txn(0, 1'b0, 32'h104, 32'h0);
    drive_reqs();
    step_access(1'b1, 1'b1, own_s);
    check_eq("t4_owner", 32'(own_s), 32'd0);
    while (pend != 2'b00) step_access(1'b0, 1'b0, own_s);

    // Reset in the first BUSY cycle.
    new_txn(0, 1'b0, 32'h40, 32'h0);
    drive_reqs();
    @(posedge clk); #1;
    check_eq("t5_pre_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_mem_req", 32'(mem_req), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    #2;
    rst = 1'b0;
    pend = 2'b00;
    model_last = 1'b1;
    exp_q.delete();
    drive_reqs();
    @(posedge clk); #1;
    check_eq("t5_idle_busy", 32'(busy), 32'd0);
    new_txn(0, 1'b0, 32'h104, 32'h0);
    drive_reqs();
    step_access(1'b0, 1'b0, own_s);
    check_eq("t5_after_owner", 32'(own_s), 32'd0);

    // Randomized traffic.
    repeat (150) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) rand_txn(i);
      drive_reqs();
      if (pend == 2'b00) begin
        @(posedge clk); #1;
        check_eq("rnd_idle_busy", 32'(busy), 32'd0);
        check_eq("rnd_idle_mem_req", 32'(mem_req), 32'd0);
        check_eq("rnd_idle_done", 32'(done), 32'd0);
      end else begin
        step_access($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, own_s);
      end
    end

    // Latency variants: LAT=1 then LAT=5, single core read each.
    for (int k = 0; k < 2; k++) begin
      done_cyc = -1;
      mreq_cnt = 0;
      done_cnt = 0;
      rd_seen  = '0;
      if (k == 0) l1_req = 2'b01; else l5_req = 2'b01;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(posedge clk); #1;
        if (k == 0 ? l1_mem_req : l5_mem_req) mreq_cnt++;
        if ((k == 0 ? l1_done[0] : l5_done[0]) == 1'b1) begin
          done_cnt++;
          if (done_cyc < 0) begin
            done_cyc = cyc;
            rd_seen  = (k == 0) ? l1_rdata : l5_rdata;
            if (k == 0) l1_req = 2'b00; else l5_req = 2'b00;
          end
        end
      end
      check_eq(k == 0 ? "lat1_done_cycle" : "lat5_done_cycle", 32'(done_cyc), k == 0 ? 32'd2 : 32'd6);
      check_eq(k == 0 ? "lat1_mem_req_cycles" : "lat5_mem_req_cycles", 32'(mreq_cnt), k == 0 ? 32'd1 : 32'd5);
      check_eq(k == 0 ? "lat1_done_width" : "lat5_done_width", 32'(done_cnt), 32'd1);
      check_eq(k == 0 ? "lat1_rdata" : "lat5_rdata", rd_seen, 32'hCAFE0000);
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
